// File: rtl/rr_replay_log_unpacker_if.sv
// rr_replay_log_unpacker_if: packed input stream plus per-channel release streams
interface rr_replay_log_unpacker_if #(
  parameter int NCH    = 5,
  parameter int DATA_W = 512,
  parameter int CH_W   = 512
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [NCH-1:0]      out_valid;
  logic [NCH-1:0]      out_ready;
  logic [NCH*CH_W-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/rr_replay_log_unpacker.sv
// rr_replay_log_unpacker: splits packed log records into per-channel streams released together
module rr_replay_log_unpacker #(
  parameter int NCH    = 5,
  parameter int DATA_W = 512,
  parameter int CH_W   = 512
) (
  input  logic                   clk,
  input  logic                   rstn,
  rr_replay_log_unpacker_if.slave bus,
  output logic [31:0]            record_cnt,
  output logic                   fmt_err,
  output logic                   idle
);
  typedef enum logic [1:0] {S_HDR, S_PAY, S_REL} state_t;
  state_t                   state;
  logic                     rdy;
  logic [NCH-1:0]           pending, rel_mask, ov, low, rest, left, mask;
  logic [NCH-1:0][CH_W-1:0] hold;
  logic                     hs;
  assign mask = bus.in_data[NCH-1:0];
  assign hs   = bus.in_valid & rdy;
  // lowest pending channel as a one-hot: payloads arrive in ascending channel order
  assign low  = pending & (~pending + NCH'(1));
  assign rest = pending & ~low;
  // channels still waiting after this cycle's output handshakes
  assign left = ov & ~bus.out_ready;
  assign bus.in_ready  = rdy;
  assign bus.out_valid = ov;
  assign bus.out_data  = hold;
  assign idle = state == S_HDR;
  // record FSM: header -> payload collection -> joint release
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state      <= S_HDR;
      rdy        <= 1'b0;
      pending    <= '0;
      rel_mask   <= '0;
      ov         <= '0;
      hold       <= '0;
      record_cnt <= '0;
      fmt_err    <= 1'b0;
    end else begin
      case (state)
        S_HDR: begin
          rdy <= 1'b1;
          if (hs) begin
            if (mask == '0 || |bus.in_data[DATA_W-1:NCH]) fmt_err <= 1'b1;
            if (mask != '0) begin
              pending  <= mask;
              rel_mask <= mask;
              state    <= S_PAY;
            end
          end
        end
        S_PAY:
          if (hs) begin
            for (int i = 0; i < NCH; i++)
              if (low[i]) hold[i] <= bus.in_data[CH_W-1:0];
            pending <= rest;
            if (rest == '0) begin
              ov    <= rel_mask;
              rdy   <= 1'b0;
              state <= S_REL;
            end
          end
        S_REL: begin
          ov <= left;
          if (left == '0) begin
            rel_mask   <= '0;
            pending    <= '0;
            record_cnt <= record_cnt + 32'd1;
            rdy        <= 1'b1;
            state      <= S_HDR;
          end
        end
        default: state <= S_HDR;
      endcase
    end
endmodule

// File: tb/tb_rr_replay_log_unpacker.sv
// tb_rr_replay_log_unpacker: directed and randomized record checks against a record-level model
module tb_rr_replay_log_unpacker;
  localparam int NCH = 5, DW = 512, CW = 512;
  logic clk = 1'b0, rstn = 1'b0;
  logic [31:0] record_cnt;
  logic fmt_err, idle;
  int errors = 0, checks = 0, cnt = 0;
  logic [CW-1:0] exp_pl [NCH];
  logic [DW-1:0] h;
  logic [NCH-1:0] m;
  rr_replay_log_unpacker_if #(.NCH(NCH), .DATA_W(DW), .CH_W(CW)) bus();
  rr_replay_log_unpacker #(.NCH(NCH), .DATA_W(DW), .CH_W(CW)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .record_cnt(record_cnt), .fmt_err(fmt_err), .idle(idle)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [CW-1:0] rnd();
    logic [CW-1:0] r;
    for (int i = 0; i < CW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_tmo", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic send_pl(input logic [NCH-1:0] msk, input int gap);
    send(DW'(msk));
    for (int i = 0; i < NCH; i++)
      if (msk[i]) begin
        repeat (gap) tick();
        send(DW'(exp_pl[i]));
      end
  endtask
  task automatic collect(input logic [NCH-1:0] msk, input bit rnd_rdy);
    logic [NCH-1:0] seen, prev, ov, r;
    int n = 0;
    seen = '0;
    prev = '0;
    chk("ov_rise", bus.out_valid, msk);
    while (seen != msk && n < 200) begin
      ov = bus.out_valid;
      chk("ov_mask", ov & ~msk, 0);
      chk("ov_hold", ov & prev, prev);
      chk("in_ready_rel", bus.in_ready, 0);
      r = rnd_rdy ? NCH'($urandom) : '1;
      bus.out_ready = r;
      for (int i = 0; i < NCH; i++)
        if (ov[i]) chk($sformatf("data%0d", i), bus.out_data[i*CW +: CW], exp_pl[i]);
      seen = seen | (ov & r);
      prev = ov & ~r;
      tick();
      n++;
    end
    bus.out_ready = '1;
    chk("seen", seen, msk);
    cnt++;
    chk("record_cnt", record_cnt, cnt);
    chk("idle", idle, 1);
    chk("ov_clear", bus.out_valid, 0);
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = '1;
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_ov", bus.out_valid, 0);
    for (int i = 0; i < NCH; i++) chk("rst_data", bus.out_data[i*CW +: CW], 0);
    chk("rst_cnt", record_cnt, 0);
    chk("rst_fmt", fmt_err, 0);
    chk("rst_idle", idle, 1);
    rstn = 1'b1;
    tick();
    chk("in_ready_up", bus.in_ready, 1);
    for (int i = 0; i < NCH; i++) exp_pl[i] = CW'('hA0 + i);
    send_pl(5'b11111, 0);
    collect(5'b11111, 1'b0);
    chk("full_in_ready", bus.in_ready, 1);
    chk("full_fmt", fmt_err, 0);
    exp_pl[1] = CW'('h11);
    exp_pl[4] = CW'('h44);
    send_pl(5'b10010, 0);
    collect(5'b10010, 1'b1);
    exp_pl[0] = rnd();
    exp_pl[1] = rnd();
    send_pl(5'b00011, 0);
    chk("stag_rise", bus.out_valid, 5'b00011);
    bus.out_ready = 5'b00001;
    tick();
    repeat (10) begin
      chk("stag_ov", bus.out_valid, 5'b00010);
      chk("stag_data", bus.out_data[CW +: CW], exp_pl[1]);
      chk("stag_in_ready", bus.in_ready, 0);
      chk("stag_cnt", record_cnt, cnt);
      tick();
    end
    bus.out_ready = 5'b00010;
    tick();
    cnt++;
    chk("stag_cnt_done", record_cnt, cnt);
    chk("stag_idle", idle, 1);
    chk("stag_ov_clear", bus.out_valid, 0);
    bus.out_ready = '1;
    send('0);
    chk("fmt_zero", fmt_err, 1);
    chk("fmt_zero_idle", idle, 1);
    chk("fmt_zero_ready", bus.in_ready, 1);
    chk("fmt_zero_ov", bus.out_valid, 0);
    chk("fmt_zero_cnt", record_cnt, cnt);
    exp_pl[0] = rnd();
    h = DW'(1);
    h[100] = 1'b1;
    send(h);
    send(DW'(exp_pl[0]));
    collect(5'b00001, 1'b1);
    chk("fmt_sticky", fmt_err, 1);
    for (int i = 0; i < 3; i++) exp_pl[i] = rnd();
    send_pl(5'b00111, 3);
    collect(5'b00111, 1'b1);
    for (int k = 0; k < 25; k++) begin
      m = NCH'($urandom_range(1, 31));
      for (int i = 0; i < NCH; i++) exp_pl[i] = rnd();
      send_pl(m, $urandom_range(0, 2));
      collect(m, 1'b1);
    end
    for (int i = 0; i < 3; i++) exp_pl[i] = rnd();
    send(DW'(7));
    send(DW'(exp_pl[0]));
    rstn = 1'b0;
    #1;
    cnt = 0;
    chk("mid_ov", bus.out_valid, 0);
    for (int i = 0; i < NCH; i++) chk("mid_data", bus.out_data[i*CW +: CW], 0);
    chk("mid_cnt", record_cnt, 0);
    chk("mid_fmt", fmt_err, 0);
    chk("mid_idle", idle, 1);
    chk("mid_in_ready", bus.in_ready, 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("mid_ready_up", bus.in_ready, 1);
    m = NCH'($urandom_range(1, 31));
    for (int i = 0; i < NCH; i++) exp_pl[i] = rnd();
    send_pl(m, 1);
    collect(m, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
